// File: rtl/viterbi_pkg.sv
// Shared constants for the rate-1/2, K=3 (7/5 octal) Viterbi decoder datapath.
// Provides the encoder trellis helper used by the ACS branch-metric logic.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 4;

    localparam logic [K-1:0] GEN0 = 3'o7;
    localparam logic [K-1:0] GEN1 = 3'o5;

    localparam int METRIC_W = 4;
    localparam int SUM_W    = METRIC_W + 1;
    localparam int PATH_W   = 8;
    localparam int PTR_W    = 3;

    localparam logic [METRIC_W-1:0] DEF_INIT_METRIC = 4'd4;
    localparam logic [METRIC_W-1:0] DEF_NORM_THRESH = 4'd8;

    localparam int ST_00 = 0;
    localparam int ST_01 = 1;
    localparam int ST_10 = 2;
    localparam int ST_11 = 3;

    // Expected code bits {g0, g1} leaving `state` on input `u`.
    function automatic logic [1:0] code_bits(input logic [1:0] state, input logic u);
        logic [K-1:0] sr;
        sr = {u, state};
        return {^(sr & GEN0), ^(sr & GEN1)};
    endfunction

endpackage

// File: rtl/acs_path_update_acs_cell.sv
// acs_cell: compare-select for one next state, picks the smaller candidate.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ties resolve to the lower predecessor; decision is the input bit into this state.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int NS = 0
) (
    input  logic [SUM_W-1:0]  cand_lo,
    input  logic [SUM_W-1:0]  cand_hi,
    input  logic [PATH_W-2:0] path_lo,
    input  logic [PATH_W-2:0] path_hi,
    output logic [SUM_W-1:0]  metric_out,
    output logic [PATH_W-2:0] path_out,
    output logic              decision
);

    logic take_hi;

    assign take_hi    = (cand_hi < cand_lo);
    assign metric_out = take_hi ? cand_hi : cand_lo;
    assign path_out   = take_hi ? path_hi : path_lo;
    assign decision   = 1'(NS / 2);

endmodule

// File: rtl/acs_path_update.sv
// acs_path_update: ACS + survivor update, metric normalization, write pointer (optional ACS_ERASURE_EN).
// Latency: 1 cycle from accepted symbol to registered outputs with valid_out pulse.
// Backpressure: none; valid_in low holds all state, refresh/rst reinitialize the frame.
module acs_path_update
    import viterbi_pkg::*;
#(
    parameter logic [METRIC_W-1:0] INIT_METRIC = DEF_INIT_METRIC,
    parameter logic [METRIC_W-1:0] NORM_THRESH = DEF_NORM_THRESH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                refresh,
    input  logic                valid_in,
    input  logic [1:0]          symbol_in,
`ifdef ACS_ERASURE_EN
    input  logic [1:0]          erase_in,
`endif
    output logic [PATH_W-1:0]   updated_selected_branch_at_00,
    output logic [PATH_W-1:0]   updated_selected_branch_at_01,
    output logic [PATH_W-1:0]   updated_selected_branch_at_10,
    output logic [PATH_W-1:0]   updated_selected_branch_at_11,
    output logic [METRIC_W-1:0] new_branch_metric_00,
    output logic [METRIC_W-1:0] new_branch_metric_01,
    output logic [METRIC_W-1:0] new_branch_metric_10,
    output logic [METRIC_W-1:0] new_branch_metric_11,
    output logic [PTR_W-1:0]    write_pointer_out,
    output logic                valid_out
);

    logic [METRIC_W-1:0] metric_q [NUM_STATES];
    logic [PATH_W-1:0]   path_q   [NUM_STATES];
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    wp_q;
    logic                vld_q;

    logic [METRIC_W-1:0] base_metric [NUM_STATES];
    logic [PATH_W-2:0]   base_path   [NUM_STATES];
    logic [PTR_W-1:0]    base_ptr;
    logic [SUM_W-1:0]    cand        [NUM_STATES][2];
    logic [SUM_W-1:0]    sel_metric  [NUM_STATES];
    logic [PATH_W-2:0]   sel_path    [NUM_STATES];
    logic                decision    [NUM_STATES];
    logic [SUM_W-1:0]    adj_metric  [NUM_STATES];
    logic [METRIC_W-1:0] next_metric [NUM_STATES];
    logic [1:0]          bit_err;
    logic [1:0]          bm;
    logic                all_ge;

    // A refresh coinciding with a symbol processes it from the initial state.
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) begin
            if (refresh) begin
                base_metric[i] = (i == ST_00) ? '0 : INIT_METRIC;
                base_path[i]   = '0;
            end else begin
                base_metric[i] = metric_q[i];
                base_path[i]   = path_q[i][PATH_W-2:0];
            end
        end
        base_ptr = refresh ? '0 : ptr_q;
    end

    always_comb begin
        cand    = '{default: '{default: '0}};
        bit_err = '0;
        bm      = '0;
        for (int ns = 0; ns < NUM_STATES; ns++) begin
            for (int j = 0; j < 2; j++) begin
                bit_err = code_bits(2'((ns % 2) * 2 + j), 1'(ns / 2)) ^ symbol_in;
`ifdef ACS_ERASURE_EN
                bit_err = bit_err & ~erase_in;
`endif
                bm          = {1'b0, bit_err[1]} + {1'b0, bit_err[0]};
                cand[ns][j] = {1'b0, base_metric[(ns % 2) * 2 + j]} + {3'b000, bm};
            end
        end
    end

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam int PLO = (g % 2) * 2;
        acs_cell #(.NS(g)) u_acs_cell (
            .cand_lo    (cand[g][0]),
            .cand_hi    (cand[g][1]),
            .path_lo    (base_path[PLO]),
            .path_hi    (base_path[PLO + 1]),
            .metric_out (sel_metric[g]),
            .path_out   (sel_path[g]),
            .decision   (decision[g])
        );
    end

    // Normalize only when every state has drifted past the threshold, keeping ordering.
    always_comb begin
        all_ge = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (sel_metric[i] < {1'b0, NORM_THRESH}) begin
                all_ge = 1'b0;
            end
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            adj_metric[i]  = all_ge ? (sel_metric[i] - {1'b0, NORM_THRESH}) : sel_metric[i];
            next_metric[i] = adj_metric[i][SUM_W-1] ? '1 : adj_metric[i][METRIC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                metric_q[i] <= (i == ST_00) ? '0 : INIT_METRIC;
                path_q[i]   <= '0;
            end
            ptr_q <= '0;
            wp_q  <= '0;
            vld_q <= 1'b0;
        end else if (valid_in) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                metric_q[i] <= next_metric[i];
                path_q[i]   <= {sel_path[i], decision[i]};
            end
            wp_q  <= base_ptr;
            ptr_q <= base_ptr + 1'b1;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
            if (refresh) begin
                for (int i = 0; i < NUM_STATES; i++) begin
                    metric_q[i] <= (i == ST_00) ? '0 : INIT_METRIC;
                    path_q[i]   <= '0;
                end
                ptr_q <= '0;
                wp_q  <= '0;
            end
        end
    end

    assign new_branch_metric_00          = metric_q[ST_00];
    assign new_branch_metric_01          = metric_q[ST_01];
    assign new_branch_metric_10          = metric_q[ST_10];
    assign new_branch_metric_11          = metric_q[ST_11];
    assign updated_selected_branch_at_00 = path_q[ST_00];
    assign updated_selected_branch_at_01 = path_q[ST_01];
    assign updated_selected_branch_at_10 = path_q[ST_10];
    assign updated_selected_branch_at_11 = path_q[ST_11];
    assign write_pointer_out             = wp_q;
    assign valid_out                     = vld_q;

endmodule

// File: tb/tb_acs_path_update.sv
// Bench for acs_path_update: forward-trellis reference model feeding a scoreboard queue.
module tb_acs_path_update;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       refresh = 1'b0;
    logic       valid_in = 1'b0;
    logic [1:0] symbol_in = 2'b00;
    logic [1:0] erase_in = 2'b00;
    logic [7:0] p00, p01, p10, p11;
    logic [3:0] m00, m01, m10, m11;
    logic [2:0] wp;
    logic       valid_out;

    int checks = 0;
    int errors = 0;

    localparam logic [50:0] RST_VEC   = {4'd0, 4'd4, 4'd4, 4'd4, 32'h0, 3'd0};
    localparam logic [50:0] FIRST_VEC = {4'd0, 4'd5, 4'd2, 4'd5, 8'h00, 8'h00, 8'h01, 8'h01, 3'd0};

    logic [50:0] obs;
    assign obs = {m00, m01, m10, m11, p00, p01, p10, p11, wp};

    always #5 clk = ~clk;

    acs_path_update dut (
        .clk                           (clk),
        .rst                           (rst),
        .refresh                       (refresh),
        .valid_in                      (valid_in),
        .symbol_in                     (symbol_in),
`ifdef ACS_ERASURE_EN
        .erase_in                      (erase_in),
`endif
        .updated_selected_branch_at_00 (p00),
        .updated_selected_branch_at_01 (p01),
        .updated_selected_branch_at_10 (p10),
        .updated_selected_branch_at_11 (p11),
        .new_branch_metric_00          (m00),
        .new_branch_metric_01          (m01),
        .new_branch_metric_10          (m10),
        .new_branch_metric_11          (m11),
        .write_pointer_out             (wp),
        .valid_out                     (valid_out)
    );

    int          mm [4];
    logic [7:0]  mp [4];
    int          mptr;
    logic [50:0] exp_hold;
    logic [50:0] sb [$];

    task automatic model_init();
        mm   = '{0, 4, 4, 4};
        mp   = '{8'h00, 8'h00, 8'h00, 8'h00};
        mptr = 0;
        exp_hold = RST_VEC;
    endtask

    // Walks every (state, input) transition forward; strict < with ascending
    // state order keeps the lower predecessor on ties.
    task automatic model_step(input logic [1:0] sym, input logic [1:0] er, input bit rf);
        int nm [4];
        logic [7:0] np [4];
        int w, ns, s1, s0, g0, g1, bmv, c;
        if (rf) model_init();
        w = mptr;
        for (int i = 0; i < 4; i++) begin
            nm[i] = 999;
            np[i] = 8'h00;
        end
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                s1 = s / 2;
                s0 = s % 2;
                ns = u * 2 + s1;
                g0 = u ^ s1 ^ s0;
                g1 = u ^ s0;
                bmv = 0;
                if (g0 != int'(sym[1]) && !er[1]) bmv++;
                if (g1 != int'(sym[0]) && !er[0]) bmv++;
                c = mm[s] + bmv;
                if (c < nm[ns]) begin
                    nm[ns] = c;
                    np[ns] = {mp[s][6:0], u[0]};
                end
            end
        end
        if (nm[0] >= 8 && nm[1] >= 8 && nm[2] >= 8 && nm[3] >= 8)
            for (int i = 0; i < 4; i++) nm[i] -= 8;
        for (int i = 0; i < 4; i++) begin
            mm[i] = (nm[i] > 15) ? 15 : nm[i];
            mp[i] = np[i];
        end
        mptr = (w + 1) % 8;
        exp_hold = {4'(mm[0]), 4'(mm[1]), 4'(mm[2]), 4'(mm[3]),
                    mp[0], mp[1], mp[2], mp[3], 3'(w)};
        sb.push_back(exp_hold);
    endtask

    task automatic drive(input bit v, input logic [1:0] sym, input bit rf, input bit r);
        valid_in  = v;
        symbol_in = sym;
        refresh   = rf;
        rst       = r;
        if (r) model_init();
        else if (v) model_step(sym, erase_in, rf);
        else if (rf) model_init();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        refresh  = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (obs !== RST_VEC || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset obs=%h exp=%h valid_out=%b exp=0", obs, RST_VEC, valid_out);
        end
    endtask

    task automatic test_first_symbol();
        logic [50:0] e;
        drive(1'b1, 2'b00, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== FIRST_VEC || obs !== e || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL first_symbol obs=%h exp=%h model=%h valid_out=%b", obs, FIRST_VEC, e, valid_out);
        end
    endtask

    task automatic test_pointer_wrap();
        logic [50:0] e;
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs !== e || wp !== 3'(i % 8) || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL pointer_wrap[%0d] obs=%h exp=%h wp=%0d exp=%0d valid_out=%b",
                         i, obs, e, wp, i % 8, valid_out);
            end
        end
    endtask

    task automatic test_hold();
        logic [50:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            checks++;
            if (obs !== exp_hold || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] obs=%h exp=%h valid_out=%b exp=0", i, obs, exp_hold, valid_out);
            end
        end
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e || wp !== 3'd1 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL hold_resume obs=%h exp=%h wp=%0d exp=1", obs, e, wp);
        end
    endtask

    task automatic test_all_ones();
        logic [50:0] e;
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 2'b11, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs !== e || valid_out !== 1'b1 ||
                (m00 >= 4'd8 && m01 >= 4'd8 && m10 >= 4'd8 && m11 >= 4'd8)) begin
                errors++;
                $display("FAIL all_ones[%0d] obs=%h exp=%h valid_out=%b", i, obs, e, valid_out);
            end
        end
    endtask

    task automatic test_refresh();
        logic [50:0] e;
        drive(1'b1, 2'b01, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 2'b00, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== FIRST_VEC || obs !== e || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL refresh_valid obs=%h exp=%h valid_out=%b", obs, FIRST_VEC, valid_out);
        end
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e || wp !== 3'd1) begin
            errors++;
            $display("FAIL refresh_next_ptr obs=%h exp=%h wp=%0d exp=1", obs, e, wp);
        end
        drive(1'b0, 2'b00, 1'b1, 1'b0);
        checks++;
        if (obs !== RST_VEC || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL refresh_idle obs=%h exp=%h valid_out=%b exp=0", obs, RST_VEC, valid_out);
        end
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 2'b01, 1'b1, 1'b1);
        checks++;
        if (obs !== RST_VEC || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid obs=%h exp=%h valid_out=%b exp=0", obs, RST_VEC, valid_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [50:0] e;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs !== e || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d] obs=%h exp=%h valid_out=%b", i, obs, e, valid_out);
            end
        end
    endtask

`ifdef ACS_ERASURE_EN
    task automatic test_erasure();
        logic [50:0] e;
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        erase_in = 2'b11;
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs !== e || {m00, m01, m10, m11} !== {4'd0, 4'd4, 4'd0, 4'd4}) begin
            errors++;
            $display("FAIL erasure_all obs=%h exp=%h", obs, e);
        end
        for (int i = 0; i < 12; i++) begin
            erase_in = 2'($urandom_range(0, 3));
            drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL erasure_mix[%0d] obs=%h exp=%h", i, obs, e);
            end
        end
        erase_in = 2'b00;
    endtask
`endif

    initial begin
        model_init();
        test_reset();
        test_first_symbol();
        test_pointer_wrap();
        test_hold();
        test_all_ones();
        test_refresh();
        test_rst_mid();
        test_back_to_back();
`ifdef ACS_ERASURE_EN
        test_erasure();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acs_path_update.md
# acs_path_update

Add-compare-select and survivor-path update stage of the rate-1/2, K=3 (generators 7/5 octal) Viterbi decoder. Consumes one received 2-bit hard-decision symbol per valid cycle, updates four 4-bit path metrics and four 8-bit survivor paths, and drives them, with a write pointer, into the downstream `selector`. It also owns metric normalization and frame restart on the selector's `refresh`.

## Interface
- `INIT_METRIC`, 4'd4: reset metric for states 01/10/11 (state 00 resets to 0)
- `NORM_THRESH`, 4'd8: normalization threshold and subtrahend
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `refresh`  in  1  from `selector`; frame restart, same effect as `rst` on metrics/paths/pointer
- `valid_in`  in  1  symbol qualifier
- `symbol_in`  in  2  received bits {c0, c1}
- `updated_selected_branch_at_00/01/10/11`  out  8 each  survivor path per state
- `new_branch_metric_00/01/10/11`  out  4 each  path metric per state
- `write_pointer_out`  out  3  slot index of the symbol just processed
- `valid_out`  out  1  outputs updated this cycle

## Operation
- State s = {s1, s0} = last two input bits; input u gives next state ns = {u, s1}; code bits g0 = u^s1^s0, g1 = u^s0.
- Predecessors of ns: {ns[0],0} (lower) and {ns[0],1} (upper); decision bit u = ns[1].
- Branch metric = Hamming distance({g0,g1}, symbol_in), range 0..2.
- Candidate = pred metric + BM, 5-bit sum; select smaller; tie -> lower predecessor.
- New path = {pred_path[6:0], ns[1]} (shift left, append decision bit).
- Normalization: if all four selected metrics >= NORM_THRESH, subtract NORM_THRESH from all before registering; any result > 15 saturates to 15.
- Write pointer: 3-bit counter, increments per accepted symbol, wraps 7 -> 0; `write_pointer_out` = pointer value before increment.
- `valid_in` low: metrics, paths, pointer and outputs hold; `valid_out` = 0.

## Timing
- Reset values: metrics {0, INIT_METRIC x3}, paths 8'h00, pointer 0, `write_pointer_out` 0, `valid_out` 0.
- Latency 1 cycle: symbol sampled at edge N, outputs and `valid_out`=1 visible after edge N.
- `valid_out` is a one-cycle pulse per accepted symbol; back-to-back symbols give back-to-back pulses.
- `rst` has priority over everything; `refresh` over `valid_in`.
- `refresh` with `valid_in`: metrics/paths reinitialized, then that symbol processed from the initial state; pointer output 0 and next pointer 1; `valid_out`=1.
- `refresh` without `valid_in`: reinitialize, `valid_out`=0.
- `rst` mid-stream: in-flight symbol discarded, all outputs to reset values next cycle.

## Configuration
- `ACS_ERASURE_EN`: adds input `erase_in[1:0]` (per bit of `symbol_in`); an erased bit contributes 0 to the branch metric.
- Without it: no `erase_in` port, every bit counts.

## Structure
- `viterbi_pkg`: K, NUM_STATES=4, generator constants, metric width 4, path width 8, pointer width 3, default INIT_METRIC/NORM_THRESH, state-index localparams.
- Sub-module `acs_cell`: one per next state; two candidate metrics/paths in, selected metric, path and decision out. Four instances; normalization and pointer in top.

## Test plan
- Reset, then symbol 2'b00 valid -> one cycle later metrics {00:0, 01:5, 10:2, 11:5}, paths {00:8'h00, 01:8'h00, 10:8'h01, 11:8'h01}, `write_pointer_out`=0, `valid_out`=1.
- Nine consecutive valid symbols -> `write_pointer_out` 0..7, then 0; `valid_out` high nine cycles.
- `valid_in` low for 3 cycles mid-stream -> all outputs hold, `valid_out`=0, pointer does not advance.
- 32 symbols 2'b11 after reset -> no metric > 15, never all four output metrics >= 8, tie rule gives lower predecessor.
- `refresh` pulse with `valid_in`=1 and symbol 2'b00 -> same outputs as first scenario, next pointer 1; `rst` mid-stream -> reset values next cycle.
- With `ACS_ERASURE_EN`, `erase_in`=2'b11 on any symbol -> all BM 0, metric ordering unchanged except normalization.
